// File: rtl/key_schedule_controller.sv
// Iterative AES-128 key-schedule sequencer. One round-expansion datapath is stepped once per
// clock and fills a register file with round keys 0..NR. The cipher core reads these keys
// through a registered read port.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   start       expand key_in; accepted only when idle or ready
//   key_in      128-bit cipher key, sampled on the edge that accepts start
//   busy        high while expanding
//   done        one-cycle pulse on entry to the ready state
//   keys_valid  high while all NR+1 round keys are stored
//   rd_addr     round-key index
//   rd_key      registered round key rk[rd_addr]; zero for indices above NR
module key_schedule_controller #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  localparam logic [3:0] NrIdx = 4'(NR);

  typedef enum logic [1:0] {StIdle, StExpand, StReady} stateE;

  stateE          stateQ, stateD;
  logic [3:0]     cntQ, cntD;
  logic           doneQ, doneD;
  logic           loadKey, writeRound;
  logic [127:0]   rk [0:NR];
  logic [127:0]   rdKeyQ;
  logic [3:0]     prevIdx;
  logic [127:0]   roundKey;

  // GF(2^8) arithmetic, AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, which maps 0 to 0) plus affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    logic [7:0] b;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Rcon for round r is x^(r-1).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h01;
    for (int unsigned i = 1; i < 16; i++) begin
      if (4'(i) < r) c = xtime(c);
    end
    return c;
  endfunction

  function automatic logic [127:0] keyExpansionRound(input logic [3:0]   roundCount,
                                                      input logic [127:0] keyIn);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = keyIn[127:96];
    w1 = keyIn[95:64];
    w2 = keyIn[63:32];
    w3 = keyIn[31:0];
    // RotWord then SubWord, then Rcon into the top byte.
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rcon(roundCount), 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign prevIdx  = cntQ - 4'd1;
  assign roundKey = keyExpansionRound(cntQ, rk[prevIdx]);

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    doneD      = 1'b0;
    loadKey    = 1'b0;
    writeRound = 1'b0;
    unique case (stateQ)
      StIdle, StReady: begin
        if (start) begin
          loadKey = 1'b1;
          cntD    = 4'd1;
          stateD  = StExpand;
        end
      end
      StExpand: begin
        // start is deliberately ignored here.
        writeRound = 1'b1;
        if (cntQ == NrIdx) begin
          stateD = StReady;
          doneD  = 1'b1;
        end else begin
          cntD = cntQ + 4'd1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      doneQ  <= doneD;
    end
  end

  // Reads see the pre-edge contents, so a same-index write returns the old key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= NR; i++) rk[i] <= '0;
      rdKeyQ <= '0;
    end else begin
      if (loadKey)    rk[0]    <= key_in;
      if (writeRound) rk[cntQ] <= roundKey;
      rdKeyQ <= (rd_addr <= NrIdx) ? rk[rd_addr] : '0;
    end
  end

  assign busy       = (stateQ == StExpand);
  assign keys_valid = (stateQ == StReady);
  assign done       = doneQ;
  assign rd_key     = rdKeyQ;

endmodule

// File: tb/tb_key_schedule_controller.sv
module tb_key_schedule_controller;

  localparam logic [127:0] FipsKey   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroRk1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroRk10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int checks   = 0;
  int failures = 0;

  key_schedule_controller #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .keys_valid(keys_valid),
    .rd_addr   (rd_addr),
    .rd_key    (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS-197 S-box table, row = high nibble.
  logic [127:0] sboxRows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] rconTab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = sboxRows[b[7:4]];
    return row[127 - 8 * b[3:0] -: 8];
  endfunction

  // Word-oriented FIPS-197 step: words 4r..4r+3 from words 4r-4..4r-1.
  function automatic logic [127:0] nextKey(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    t = {w[3][23:0], w[3][31:24]};
    t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rconTab[r], 24'h0};
    w[0] = w[0] ^ t;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i - 1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // Reference model: step = next round-key index to write, 0 when not expanding.
  int           mdlStep;
  bit           mdlValid;
  bit           mdlDone;
  logic [127:0] mdlRk [0:10];
  logic [127:0] mdlRd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdlStep  <= 0;
      mdlValid <= 1'b0;
      mdlDone  <= 1'b0;
      mdlRd    <= '0;
      for (int i = 0; i <= 10; i++) mdlRk[i] <= '0;
    end else begin
      mdlRd   <= (rd_addr <= 4'd10) ? mdlRk[rd_addr] : '0;
      mdlDone <= 1'b0;
      if (mdlStep == 0) begin
        if (start) begin
          mdlRk[0] <= key_in;
          mdlStep  <= 1;
          mdlValid <= 1'b0;
        end
      end else begin
        mdlRk[mdlStep] <= nextKey(mdlRk[mdlStep - 1], mdlStep);
        if (mdlStep == 10) begin
          mdlStep  <= 0;
          mdlDone  <= 1'b1;
          mdlValid <= 1'b1;
        end else begin
          mdlStep <= mdlStep + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_busy", 128'(busy), 128'(mdlStep != 0));
    chk("cyc_done", 128'(done), 128'(mdlDone));
    chk("cyc_keys_valid", 128'(keys_valid), 128'(mdlValid));
    chk("cyc_rd_key", rd_key, mdlRd);
  end

  task automatic doStart(input logic [127:0] k);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Returns the number of edges after acceptance until done is seen, or -1 on timeout.
  task automatic waitDone(input bit disturb, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      if (disturb) begin
        start  = (i == 3 || i == 4);
        key_in = 128'hdeadbeef_00112233_44556677_8899aabb;
      end
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic readChk(input string name, input logic [3:0] a, input logic [127:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk(name, rd_key, exp);
  endtask

  task automatic chkAllZero(input string name);
    chk({name, "_busy"}, 128'(busy), 128'h0);
    chk({name, "_done"}, 128'(done), 128'h0);
    chk({name, "_kv"}, 128'(keys_valid), 128'h0);
    chk({name, "_rd_key"}, rd_key, 128'h0);
  endtask

  int n;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    key_in  = '0;
    rd_addr = '0;
    #23 rst_n = 1'b1;

    // Empty register file reads as zero at every index.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
    end
    @(negedge clk);
    chk("post_reset_read", rd_key, 128'h0);

    // FIPS-197 schedule.
    doStart(FipsKey);
    chk("fips_busy", 128'(busy), 128'h1);
    waitDone(1'b0, n);
    chk("fips_done_latency", 128'(n), 128'd10);
    readChk("fips_rk0", 4'd0, FipsKey);
    readChk("fips_rk1", 4'd1, FipsRk1);
    readChk("fips_rk10", 4'd10, FipsRk10);

    // Asynchronous reset in the middle of a clock phase.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chkAllZero("async_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    readChk("after_reset_rk10", 4'd10, 128'h0);

    // Restart from READY with the all-zero key.
    doStart(FipsKey);
    waitDone(1'b0, n);
    chk("ready_kv", 128'(keys_valid), 128'h1);
    doStart(128'h0);
    chk("restart_kv_drop", 128'(keys_valid), 128'h0);
    waitDone(1'b0, n);
    chk("zero_done_latency", 128'(n), 128'd10);
    readChk("zero_rk1", 4'd1, ZeroRk1);
    readChk("zero_rk10", 4'd10, ZeroRk10);

    // start pulses during expansion are ignored.
    doStart(FipsKey);
    waitDone(1'b1, n);
    chk("ignore_done_latency", 128'(n), 128'd10);
    readChk("ignore_rk1", 4'd1, FipsRk1);
    readChk("ignore_rk10", 4'd10, FipsRk10);

    // Reset after four expansion cycles, then a clean restart.
    doStart(FipsKey);
    repeat (4) @(negedge clk);
    chk("abort_pre_done", 128'(done), 128'h0);
    #2 rst_n = 1'b0;
    #1 chkAllZero("abort_reset");
    #5 rst_n = 1'b1;
    doStart(FipsKey);
    waitDone(1'b0, n);
    chk("abort_done_latency", 128'(n), 128'd10);
    readChk("abort_rk10", 4'd10, FipsRk10);

    // Out-of-range indices read as zero.
    for (int i = 11; i < 16; i++) readChk("oob_read", 4'(i), 128'h0);

    // Back-to-back reads, one-cycle latency each.
    @(negedge clk);
    rd_addr = 4'd0;
    @(negedge clk);
    chk("b2b_rk0", rd_key, FipsKey);
    rd_addr = 4'd5;
    @(negedge clk);
    chk("b2b_rk5", rd_key, mdlRk[5]);
    rd_addr = 4'd10;
    @(negedge clk);
    chk("b2b_rk10", rd_key, FipsRk10);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
